pr_free_list_bank: RTL

PR_FREE_LIST_BANK -- requirements
Module: pr_free_list_bank

---
 rtl/pr_free_list_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/pr_free_list_bank.sv
// Per-bank physical-register free list: circular FIFO of 5-bit upper PR values
// with occupancy watermarks and a pulse that flags enqueues dropped for carrying the wrong bank.
module pr_free_list_bank #(
  parameter int BANK            = 0,
  parameter int LENGTH          = 32,
  parameter int INIT_FREE_COUNT = 16,
  parameter int INIT_UPPER_BASE = 16,
  parameter int LOWER_THRESHOLD = 8,
  parameter int UPPER_THRESHOLD = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enq_valid,
  input  logic [6:0] enq_PR,
  output logic       enq_ready,
  output logic       deq_valid,
  output logic [6:0] deq_PR,
  input  logic       deq_ready,
  output logic [5:0] count,
  output logic       below_lower,
  output logic       above_upper,
  output logic       bank_err
);

  localparam logic [1:0] BANK_ID   = 2'(BANK);
  localparam logic [5:0] LEN       = 6'(LENGTH);
  localparam logic [5:0] LOW_MARK  = 6'(LOWER_THRESHOLD);
  localparam logic [5:0] HIGH_MARK = 6'(UPPER_THRESHOLD);
  localparam logic [5:0] INIT_CNT  = 6'(INIT_FREE_COUNT);
  localparam logic [4:0] INIT_TAIL = 5'(INIT_FREE_COUNT % LENGTH);
  localparam logic [4:0] LAST_IDX  = 5'(LENGTH - 1);

  logic [4:0] mem [LENGTH];
  logic [4:0] head;
  logic [4:0] tail;
  logic       bank_match;
  logic       do_enq;
  logic       do_deq;
  logic       bank_drop;

  // Explicit wrap keeps the pointers correct for non-power-of-two LENGTH.
  function automatic logic [4:0] next_ptr(input logic [4:0] p);
    return (p == LAST_IDX) ? 5'd0 : p + 5'd1;
  endfunction

  // Handshake, status flags and the head entry are pure functions of the registered state.
  always_comb begin
    enq_ready   = (count != LEN);
    deq_valid   = (count != 6'd0);
    deq_PR      = {mem[head], BANK_ID};
    below_lower = (count < LOW_MARK);
    above_upper = (count > HIGH_MARK);
    bank_match  = (enq_PR[1:0] == BANK_ID);
    do_enq      = enq_valid & enq_ready & bank_match;
    bank_drop   = enq_valid & enq_ready & ~bank_match;
    do_deq      = deq_valid & deq_ready;
  end

  // FIFO state; reset wins over any concurrent enqueue or dequeue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head     <= 5'd0;
      tail     <= INIT_TAIL;
      count    <= INIT_CNT;
      bank_err <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        mem[i] <= (i < INIT_FREE_COUNT) ? 5'(INIT_UPPER_BASE + i) : 5'd0;
      end
    end else begin
      bank_err <= bank_drop;
      if (do_enq) begin
        mem[tail] <= enq_PR[6:2];
        tail      <= next_ptr(tail);
      end
      if (do_deq) begin
        head <= next_ptr(head);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
